// File: rtl/param_counter_pkg.sv
// Shared types and constants for the param_counter block.
// Build option: define PARAM_COUNTER_SAT_EN to saturate at the count
// boundaries instead of wrapping.
package param_counter_pkg;

    // Legal range of the WIDTH parameter
    localparam int unsigned PCNT_WIDTH_MIN = 2;
    localparam int unsigned PCNT_WIDTH_MAX = 32;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pcnt_state_t;

endpackage : param_counter_pkg

// File: rtl/pcnt_next.sv
// Combinational next-count and terminal-detect unit for param_counter.
// Build option: PARAM_COUNTER_SAT_EN selects saturating behaviour at the
// boundaries. Without it, the count wraps to the opposite boundary.
module pcnt_next #(
    parameter int unsigned          WIDTH   = 8,
    parameter logic [WIDTH-1:0]     MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             up,
    output logic [WIDTH-1:0] cnt_nxt,
    output logic             term,
    output logic             tc_nxt
);

    logic [WIDTH-1:0] bound;
    logic [WIDTH-1:0] step;

    // Boundary compare and one-step move in the selected direction; the
    // boundary is tested explicitly because MAX_VAL may sit below the
    // natural WIDTH-bit overflow point.
    always_comb begin
        bound = up ? MAX_VAL : '0;
        term  = (cnt == bound);
        step  = up ? (cnt + WIDTH'(1)) : (cnt - WIDTH'(1));
`ifdef PARAM_COUNTER_SAT_EN
        // Hold at the boundary; pulse only on the step that arrives there.
        cnt_nxt = term ? cnt : step;
        tc_nxt  = !term && (step == bound);
`else
        // Jump to the opposite boundary and pulse on the wrap itself.
        cnt_nxt = term ? (up ? '0 : MAX_VAL) : step;
        tc_nxt  = term;
`endif
    end

endmodule : pcnt_next

// File: rtl/param_counter.sv
// Loadable up/down counter with configurable terminal value, optional
// one-shot stop and a registered terminal-count pulse.
// Build option: define PARAM_COUNTER_SAT_EN to saturate at the boundaries
// instead of wrapping (one-shot behaviour is unaffected).
module param_counter
    import param_counter_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter bit               ONESHOT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] cnt,
    output logic             val,
    output logic             tc
);

    // Reject illegal widths at elaboration
    if (WIDTH < PCNT_WIDTH_MIN || WIDTH > PCNT_WIDTH_MAX) begin : g_width_check
        $error("param_counter: WIDTH out of legal range");
    end

    pcnt_state_t      state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             val_q, val_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] cnt_nxt;
    logic             term;
    logic             tc_nxt;
    logic [WIDTH-1:0] load_val;

    pcnt_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .cnt     (cnt_q),
        .up      (up),
        .cnt_nxt (cnt_nxt),
        .term    (term),
        .tc_nxt  (tc_nxt)
    );

    // Load value clamped into 0..MAX_VAL
    always_comb begin
        load_val = (data > MAX_VAL) ? MAX_VAL : data;
    end

    // FSM next-state and next-output decode
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        tc_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ld) begin
                    cnt_d   = load_val;
                    val_d   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ld) begin
                    cnt_d = load_val;
                    val_d = 1'b1;
                end else if (en) begin
                    if (ONESHOT && term) begin
                        // Stop at the boundary instead of moving past it
                        state_d = DONE;
                        tc_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_nxt;
                        tc_d  = tc_nxt;
                    end
                end
            end
            DONE: begin
                if (ld) begin
                    cnt_d   = load_val;
                    val_d   = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            val_q   <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            tc_q    <= tc_d;
        end
    end

    assign cnt = cnt_q;
    assign val = val_q;
    assign tc  = tc_q;

endmodule : param_counter

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter: four instances with different
// parameters share one stimulus stream; a modular-arithmetic reference model
// predicts every output each cycle, and directed tables/sequences pin the
// corner cases to hand-derived constants.
module tb_param_counter;

    logic       clk;
    logic       rst_n;
    logic       ld;
    logic       en;
    logic       up;
    logic [7:0] data;

    logic [7:0] cnt_a, cnt_b, cnt_c;
    logic [3:0] cnt_d;
    logic       val_a, val_b, val_c, val_d;
    logic       tc_a, tc_b, tc_c, tc_d;

    int n_tests = 0;
    int n_fail  = 0;

    // a: WIDTH=8 full range; b: MAX_VAL=9; c: MAX_VAL=3 one-shot; d: WIDTH=4
    param_counter #(.WIDTH(8)) u_a (
        .clk(clk), .rst(rst_n), .ld(ld), .en(en), .up(up), .data(data),
        .cnt(cnt_a), .val(val_a), .tc(tc_a));
    param_counter #(.WIDTH(8), .MAX_VAL(8'd9)) u_b (
        .clk(clk), .rst(rst_n), .ld(ld), .en(en), .up(up), .data(data),
        .cnt(cnt_b), .val(val_b), .tc(tc_b));
    param_counter #(.WIDTH(8), .MAX_VAL(8'd3), .ONESHOT(1'b1)) u_c (
        .clk(clk), .rst(rst_n), .ld(ld), .en(en), .up(up), .data(data),
        .cnt(cnt_c), .val(val_c), .tc(tc_c));
    param_counter #(.WIDTH(4)) u_d (
        .clk(clk), .rst(rst_n), .ld(ld), .en(en), .up(up), .data(data[3:0]),
        .cnt(cnt_d), .val(val_d), .tc(tc_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int unsigned m_max [4] = '{255, 9, 3, 15};
    bit          m_os  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int          m_st  [4];   // 0 idle, 1 run, 2 done
    int unsigned m_cnt [4];
    bit          m_val [4];
    bit          m_tc  [4];
    bit          sat_mode;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_val[i] = 1'b0; m_tc[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < 4; i++) begin
            int unsigned mx  = m_max[i];
            int unsigned d   = (i == 3) ? (int'(data) % 16) : int'(data);
            int unsigned nxt;
            int unsigned bnd;
            bit          at_bnd;
            m_tc[i] = 1'b0;
            if (!rst_n) begin
                m_st[i] = 0; m_cnt[i] = 0; m_val[i] = 1'b0;
                continue;
            end
            if (ld) begin
                m_cnt[i] = (d > mx) ? mx : d;
                m_val[i] = 1'b1;
                m_st[i]  = 1;
            end else if (m_st[i] == 1 && en) begin
                nxt    = up ? (m_cnt[i] + 1) % (mx + 1) : (m_cnt[i] + mx) % (mx + 1);
                bnd    = up ? mx : 0;
                at_bnd = (m_cnt[i] == bnd);
                if (m_os[i] && at_bnd) begin
                    m_st[i] = 2;
                    m_tc[i] = 1'b1;
                end else if (sat_mode) begin
                    if (!at_bnd) begin
                        m_cnt[i] = nxt;
                        m_tc[i]  = (nxt == bnd);
                    end
                end else begin
                    m_cnt[i] = nxt;
                    m_tc[i]  = at_bnd;
                end
            end
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] act_cnt(input int i);
        case (i)
            0: return 32'(cnt_a);
            1: return 32'(cnt_b);
            2: return 32'(cnt_c);
            default: return 32'(cnt_d);
        endcase
    endfunction

    function automatic logic [31:0] act_val(input int i);
        case (i)
            0: return 32'(val_a);
            1: return 32'(val_b);
            2: return 32'(val_c);
            default: return 32'(val_d);
        endcase
    endfunction

    function automatic logic [31:0] act_tc(input int i);
        case (i)
            0: return 32'(tc_a);
            1: return 32'(tc_b);
            2: return 32'(tc_c);
            default: return 32'(tc_d);
        endcase
    endfunction

    task automatic compare_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s dut%0d cnt", tag, i), act_cnt(i), 32'(m_cnt[i]));
            check($sformatf("%s dut%0d val", tag, i), act_val(i), 32'(m_val[i]));
            check($sformatf("%s dut%0d tc",  tag, i), act_tc(i),  32'(m_tc[i]));
        end
    endtask

    task automatic set_in(input logic l, input logic e, input logic u, input logic [7:0] d);
        ld = l; en = e; up = u; data = d;
    endtask

    // One clock: model follows the edge, outputs sampled 1 ns later
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    // ---------------- directed vectors for instance b (MAX_VAL=9) ----------------
    typedef struct {
        logic       ld;
        logic       en;
        logic       up;
        logic [7:0] data;
        logic [7:0] exp_cnt;
        logic       exp_tc;
        logic       exp_val;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic l, input logic e, input logic u, input logic [7:0] d,
                                input logic [7:0] c, input logic t);
        vec_t v;
        v.ld = l; v.en = e; v.up = u; v.data = d;
        v.exp_cnt = c; v.exp_tc = t; v.exp_val = 1'b1;
        vecs.push_back(v);
    endfunction

    initial begin
        int unsigned exp_c38 [7];
        bit          exp_t38 [7];
        int unsigned exp_c39 [5];
        bit          exp_t39 [5];

`ifdef PARAM_COUNTER_SAT_EN
        sat_mode = 1'b1;
`else
        sat_mode = 1'b0;
`endif

        // ld/en/up/data -> cnt/tc; first entry loads on the first edge after reset
        add(1, 0, 0, 8'd8, 8'd8, 0);
`ifdef PARAM_COUNTER_SAT_EN
        add(0, 1, 1, 8'd0, 8'd9, 1);   // first arrival at MAX_VAL pulses
        add(0, 1, 1, 8'd0, 8'd9, 0);   // held, no pulse
        add(0, 1, 1, 8'd0, 8'd9, 0);
        add(1, 0, 0, 8'd12, 8'd9, 0);  // clamp
        add(1, 0, 0, 8'd0, 8'd0, 0);
        add(0, 1, 0, 8'd0, 8'd0, 0);   // held at 0 going down
        add(0, 1, 0, 8'd0, 8'd0, 0);
        add(0, 0, 1, 8'd0, 8'd0, 0);   // hold
`else
        add(0, 1, 1, 8'd0, 8'd9, 0);
        add(0, 1, 1, 8'd0, 8'd0, 1);   // wrap up
        add(0, 1, 1, 8'd0, 8'd1, 0);
        add(1, 0, 0, 8'd12, 8'd9, 0);  // clamp
        add(1, 0, 0, 8'd0, 8'd0, 0);
        add(0, 1, 0, 8'd0, 8'd9, 1);   // wrap down
        add(0, 1, 0, 8'd0, 8'd8, 0);
        add(0, 0, 1, 8'd0, 8'd8, 0);   // hold
`endif
        add(1, 0, 0, 8'd4, 8'd4, 0);
        add(1, 1, 1, 8'd7, 8'd7, 0);   // ld beats en
        add(1, 0, 0, 8'd9, 8'd9, 0);
        add(1, 1, 1, 8'd3, 8'd3, 0);   // ld beats a terminal event
        add(0, 1, 0, 8'd0, 8'd2, 0);

        // One-shot sequence on instance c (MAX_VAL=3): ld 2, up x3, down, ld 1, up
        exp_c38 = '{2, 3, 3, 3, 3, 1, 2};
`ifdef PARAM_COUNTER_SAT_EN
        exp_t38 = '{0, 1, 1, 0, 0, 0, 0};
        exp_c39 = '{14, 15, 15, 15, 15};
        exp_t39 = '{0, 1, 0, 0, 0};
`else
        exp_t38 = '{0, 0, 1, 0, 0, 0, 0};
        exp_c39 = '{14, 15, 0, 1, 2};
        exp_t39 = '{0, 0, 1, 0, 0};
`endif

        // ---- reset state (ld pending during reset must be ignored) ----
        model_reset();
        rst_n = 1'b0;
        set_in(1, 1, 1, 8'd55);
        repeat (3) cycle("reset");
        check("reset cnt_a", 32'(cnt_a), 32'd0);
        check("reset val_a", 32'(val_a), 32'd0);
        check("reset tc_a",  32'(tc_a),  32'd0);

        // ---- table-driven vectors ----
        rst_n = 1'b1;
        foreach (vecs[k]) begin
            set_in(vecs[k].ld, vecs[k].en, vecs[k].up, vecs[k].data);
            cycle($sformatf("vec%0d", k));
            check($sformatf("vec%0d cnt_b", k), 32'(cnt_b), 32'(vecs[k].exp_cnt));
            check($sformatf("vec%0d tc_b",  k), 32'(tc_b),  32'(vecs[k].exp_tc));
            check($sformatf("vec%0d val_b", k), 32'(val_b), 32'(vecs[k].exp_val));
        end

        // ---- one-shot stop in DONE and restart by load ----
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: set_in(1, 0, 1, 8'd2);
                4: set_in(0, 1, 0, 8'd0);
                5: set_in(1, 0, 1, 8'd1);
                default: set_in(0, 1, 1, 8'd0);
            endcase
            cycle($sformatf("oneshot%0d", k));
            check($sformatf("oneshot%0d cnt_c", k), 32'(cnt_c), 32'(exp_c38[k]));
            check($sformatf("oneshot%0d tc_c",  k), 32'(tc_c),  32'(exp_t38[k]));
        end

        // ---- WIDTH=4 upper boundary (saturate or wrap per build) ----
        for (int k = 0; k < 5; k++) begin
            if (k == 0) set_in(1, 0, 1, 8'd14);
            else        set_in(0, 1, 1, 8'd0);
            cycle($sformatf("w4_%0d", k));
            check($sformatf("w4_%0d cnt_d", k), 32'(cnt_d), 32'(exp_c39[k]));
            check($sformatf("w4_%0d tc_d",  k), 32'(tc_d),  32'(exp_t39[k]));
        end

        // ---- asynchronous reset in the middle of a count ----
        set_in(1, 0, 1, 8'd5);
        cycle("midrst load");
        set_in(0, 1, 1, 8'd0);
        repeat (3) cycle("midrst count");
        check("midrst pre cnt_a", 32'(cnt_a), 32'd8);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst cnt_a", 32'(cnt_a), 32'd0);
        check("midrst val_a", 32'(val_a), 32'd0);
        check("midrst tc_a",  32'(tc_a),  32'd0);
        compare_all("midrst");
        cycle("midrst hold");

        // ---- randomized stimulus against the model ----
        rst_n = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            logic [7:0] pick;
            logic [7:0] d_tab [10];
            d_tab = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd8, 8'd9, 8'd14, 8'd15, 8'd254, 8'd255};
            if ($urandom_range(0, 1) == 0) pick = d_tab[$urandom_range(0, 9)];
            else                           pick = 8'($urandom);
            rst_n = ($urandom_range(0, 127) != 0);
            ld    = ($urandom_range(0, 15) == 0);
            en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) up = ~up;
            data  = pick;
            cycle($sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_param_counter
